fp_addsub_pipe_sched: RTL
=========================

// Module: fp_addsub_pipe_sched
// PURPOSE
//  Schedules the pipelined FP add/sub datapath (unpack/compare -> swap/align/invert -> add -> normalise/round)
//  between NumReq requesters. Round-robin arbitrates issue and drives per-stage register load enables.
//  Tracks a valid bit and requester ID per stage, and returns each result to its originating requester.
//  Holds no operand data; steers the operand mux and the stage registers around the datapath.
// PARAMETERS
//  NumStages  4  number of pipeline register stages in the add/sub datapath (>=2)
//  NumReq     2  number of requesters sharing the unit (>=2)
//  IdWidth    1  requester ID width; must equal $clog2(NumReq)
// PORTS
//  Clk         in   1          single clock, all state on rising edge
//  Reset       in   1          synchronous, active-high
//  Flush       in   1          sync clear of all in-flight ops; lower priority than Reset
//  ReqValid    in   NumReq     requester k presents an operation
//  ReqReady    out  NumReq     one-hot grant; op k accepted when ReqValid[k]&ReqReady[k]
//  IssueId     out  IdWidth    operand-mux select into stage-1 register; valid when any ReqReady set
//  StageEn     out  NumStages  load enable of stage-i pipeline register (bit 0 = input register)
//  StageValid  out  NumStages  stage i holds a live op
//  RespValid   out  NumReq     one-hot; last stage holds result for requester k
//  RespReady   in   NumReq     requester k accepts its result
//  RespId      out  IdWidth    ID of op in last stage (0 when empty)
//  Busy        out  1          any StageValid set
// BEHAVIOUR
//  - Reset: all valid bits 0, all ID regs 0, RR pointer 0; hence ReqReady/RespValid/StageEn/StageValid=0, Busy=0.
//  - Advance rule (combinational, evaluated from last stage back to stage 0):
//    adv[N-1] = valid[N-1] & RespReady[id[N-1]].
//    free[i] = ~valid[i] | adv[i].
//    StageEn[i] = (i==0 ? accept : valid[i-1]) & free[i].
//    adv[i] = valid[i] & free[i+1] for i<N-1.
//  - Bubbles collapse: an empty stage loads even when downstream is stalled; no skid buffer.
//  - Full pipe, result not taken: all stages hold; ReqReady = 0.
//  - Full pipe, result taken: every stage shifts in the same cycle. A new op is accepted that cycle,
//    giving sustained throughput of 1 op/clk.
//  - Arbitration: winner = first k with ReqValid[k] set, scanning from ptr upward mod NumReq.
//    ReqReady[winner] = free[0] & ~Flush.
//    accept = |(ReqValid & ReqReady).
//    On accept: ptr <= winner+1 mod NumReq. Otherwise ptr holds.
//  - IssueId = winner; id[0] <= winner when StageEn[0].
//  - Latency: accept at cycle t -> RespValid at t+NumStages with no stalls.
//  - Ordering: results return in issue order (in-order pipe). RespValid is one-hot or zero.
//    A stalled result does not block ReqReady while free[0] is set.
//  - Valid/ID update: valid[i] <= StageEn[i] ? 1 : (adv[i] ? 0 : valid[i]). ID moves with valid.
//  - Flush: next cycle all valid=0; ptr unchanged; no accept and no StageEn in the flush cycle.
//    Any RespValid shown in the flush cycle is still a legal handshake.
//  - Reset mid-operation: identical to the reset state; in-flight ops are dropped silently.
//  - ReqValid dropping without a grant is tolerated; the arbiter re-evaluates every cycle.
// STRUCTURE
//  - Package fp_addsub_pkg: NUM_STAGES, NUM_REQ, ID_W constants and a stage-status struct {valid, id}.
//    The datapath stage wrappers share this package.
//  - Sub-module rr_arbiter: parameterised NumReq; ReqValid + Enable in, one-hot grant + index out;
//    pointer updated on Accept.
//  - Top holds: valid/ID shift chain, advance/free logic, Flush handling.
// TESTING
//  1 Reset then single op from req0 at cycle 0: ReqReady=01, StageEn walks 0001->1000;
//    RespValid=01 at cycle 4; RespReady=1 -> Busy=0 at cycle 5.
//  2 Both ReqValid=11 continuously, RespReady=11: grants alternate 01,10,01,...; RespId follows 0,1,0,1
//    from cycle 4; 1 op/clk.
//  3 Fill pipe (4 ops), then hold RespReady=00 for 3 cycles: StageEn=0000, ReqReady=00, IDs frozen.
//    Release -> four results in issue order, one per cycle.
//  4 Bubble collapse: ops at cycles 0 and 2, RespReady=0 from cycle 3: second op advances until
//    adjacent to the first (StageValid=1100 by cycle 5), then holds.
//  5 Flush with 3 ops in flight and ReqValid=01: ReqReady=00 in the flush cycle; StageValid=0000 next cycle;
//    next grant goes to the requester after the last grant.
//  6 Reset asserted with a full pipe and a stalled result: next cycle all outputs 0, ptr=0;
//    a request in the following cycle is granted to req0.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared constants and stage-status type for the FP add/sub pipeline and its scheduler.
package fp_addsub_pkg;

   localparam int unsigned NUM_STAGES = 4;
   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned ID_W       = 1;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } stage_status_t;

endpackage

// File: rtl/fp_addsub_pipe_sched_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward, pointer moves past the winner on Accept.
module rr_arbiter #(
   parameter int unsigned NumReq  = 2,
   parameter int unsigned IdWidth = $clog2(NumReq)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NumReq-1:0]  ReqValid,
   input  logic               Enable,
   input  logic               Accept,
   output logic [NumReq-1:0]  Grant,
   output logic [IdWidth-1:0] GrantIdx
);

   logic [IdWidth-1:0] ptr_q, ptr_d;
   logic [IdWidth-1:0] cand;
   logic               found;

   always_comb begin
      found    = 1'b0;
      cand     = '0;
      GrantIdx = '0;
      for (int unsigned o = 0; o < NumReq; o++) begin
         cand = IdWidth'((32'(ptr_q) + o) % NumReq);
         if (!found && ReqValid[cand]) begin
            found    = 1'b1;
            GrantIdx = cand;
         end
      end
      Grant = (found && Enable) ? (NumReq'(1) << GrantIdx) : '0;
      ptr_d = Accept ? IdWidth'((32'(GrantIdx) + 1) % NumReq) : ptr_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fp_addsub_pipe_sched.sv
// Issue scheduler for the pipelined FP add/sub unit: arbitration, per-stage load enables,
// valid/ID tracking and result routing back to the originating requester.
module fp_addsub_pipe_sched
   import fp_addsub_pkg::*;
#(
   parameter int unsigned NumStages = NUM_STAGES,
   parameter int unsigned NumReq    = NUM_REQ,
   parameter int unsigned IdWidth   = ID_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Flush,
   input  logic [NumReq-1:0]    ReqValid,
   output logic [NumReq-1:0]    ReqReady,
   output logic [IdWidth-1:0]   IssueId,
   output logic [NumStages-1:0] StageEn,
   output logic [NumStages-1:0] StageValid,
   output logic [NumReq-1:0]    RespValid,
   input  logic [NumReq-1:0]    RespReady,
   output logic [IdWidth-1:0]   RespId,
   output logic                 Busy
);

   logic [NumStages-1:0] valid_q, valid_d;
   logic [IdWidth-1:0]   id_q [NumStages];
   logic [IdWidth-1:0]   id_d [NumStages];
   logic [NumStages-1:0] adv, free, stage_en;
   logic [NumReq-1:0]    grant;
   logic [IdWidth-1:0]   winner;
   logic                 accept;

   rr_arbiter #(
      .NumReq  (NumReq),
      .IdWidth (IdWidth)
   ) u_arb (
      .Clk      (Clk),
      .Reset    (Reset),
      .ReqValid (ReqValid),
      .Enable   (free[0] & ~Flush),
      .Accept   (accept),
      .Grant    (grant),
      .GrantIdx (winner)
   );

   // Advance/free resolved from the output end so a taken result lets the whole pipe shift.
   always_comb begin
      adv              = '0;
      free             = '0;
      adv[NumStages-1]  = valid_q[NumStages-1] & RespReady[id_q[NumStages-1]];
      free[NumStages-1] = ~valid_q[NumStages-1] | adv[NumStages-1];
      for (int i = NumStages - 2; i >= 0; i--) begin
         adv[i]  = valid_q[i] & free[i+1];
         free[i] = ~valid_q[i] | adv[i];
      end
   end

   assign accept = |(ReqValid & grant);

   always_comb begin
      stage_en    = '0;
      stage_en[0] = accept;
      for (int i = 1; i < NumStages; i++) begin
         stage_en[i] = valid_q[i-1] & free[i] & ~Flush;
      end
      valid_d = '0;
      for (int i = 0; i < NumStages; i++) begin
         valid_d[i] = ~Flush & (stage_en[i] | (valid_q[i] & ~adv[i]));
      end
      id_d[0] = stage_en[0] ? winner : id_q[0];
      for (int i = 1; i < NumStages; i++) begin
         id_d[i] = stage_en[i] ? id_q[i-1] : id_q[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q <= '0;
         for (int i = 0; i < NumStages; i++) begin
            id_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < NumStages; i++) begin
            id_q[i] <= id_d[i];
         end
      end
   end

   assign ReqReady   = grant;
   assign IssueId    = winner;
   assign StageEn    = stage_en;
   assign StageValid = valid_q;
   assign Busy       = |valid_q;
   assign RespId     = valid_q[NumStages-1] ? id_q[NumStages-1] : '0;
   assign RespValid  = valid_q[NumStages-1] ? (NumReq'(1) << id_q[NumStages-1]) : '0;

endmodule
